stack_pointer_unit: RTL
=======================

STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning stack pointer and bus width in bits (WIDTH >= 4).
REQ-002 SHALL provide parameter PAGE, default 8'h01, meaning constant high address byte driven while the stack is addressed.
REQ-003 SHALL provide parameter RESET_VALUE, default 'hFD, meaning value loaded into S by reset.
REQ-004 SHALL provide parameter MAX_BURST, default 3, meaning maximum burst push length (1..7).
REQ-005 phi2  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 systemBus_IN  input  WIDTH  load data.
REQ-008 load_EN  input  1  load S from systemBus_IN (TXS).
REQ-009 push_EN  input  1  single push: S <= S-1.
REQ-010 pop_EN  input  1  single pop: S <= S+1.
REQ-011 hold_EN  input  1  freeze all state (RDY low).
REQ-012 burst_START  input  1  begin multi-byte push sequence.
REQ-013 burst_LEN  input  3  number of pushes in burst.
REQ-014 flagClear_EN  input  1  clear sticky wrap flag.
REQ-015 systemBusWrite_EN, addressLowWrite_EN  input  1 each  output drive enables.
REQ-016 systemBus_OUT  output  WIDTH  S when systemBusWrite_EN else all ones.
REQ-017 addressLow_OUT  output  WIDTH  S when addressLowWrite_EN else all ones.
REQ-018 addressHigh_OUT  output  8  PAGE when addressLowWrite_EN else 8'hFF.
REQ-019 burstBusy_OUT  output  1  high while in BURST state.
REQ-020 burstRemain_OUT  output  3  pushes remaining in burst.
REQ-021 burstDone_OUT  output  1  one-cycle pulse after last burst push.
REQ-022 wrap_FLAG  output  1  sticky: S wrapped on push or pop.

Function
REQ-023 S SHALL be a WIDTH-bit register; all arithmetic modulo 2^WIDTH.
REQ-024 Drive outputs (REQ-016..018) SHALL be combinational from S and enables; idle value all ones.
REQ-025 Per-edge priority SHALL be: reset > hold_EN > BURST step > load_EN > push/pop.
REQ-026 hold_EN high SHALL freeze S, FSM state, burstRemain_OUT, wrap_FLAG; burstDone_OUT SHALL be 0 while held.
REQ-027 push_EN and pop_EN both high SHALL leave S unchanged, no flag.
REQ-028 Push with S=0 SHALL yield all ones and set wrap_FLAG; pop with S=all ones SHALL yield 0 and set wrap_FLAG.
REQ-029 wrap_FLAG SHALL stay set until flagClear_EN; a wrap in the same cycle as flagClear_EN SHALL leave it set.
REQ-030 FSM states SHALL be IDLE, BURST, DONE.
REQ-031 IDLE -> BURST on burst_START with 1 <= burst_LEN <= MAX_BURST; burstRemain_OUT <= burst_LEN; S unchanged that edge.
REQ-032 burst_START with burst_LEN 0 or > MAX_BURST SHALL be ignored.
REQ-033 In BURST each non-held edge SHALL decrement S (wrap rules apply) and burstRemain_OUT; at burstRemain_OUT 1 -> 0 go DONE.
REQ-034 DONE SHALL assert burstDone_OUT for exactly one cycle, then return IDLE; load/push/pop honoured in DONE.
REQ-035 In BURST, load_EN, push_EN, pop_EN, burst_START SHALL be ignored.
REQ-036 Burst latency SHALL be N+1 edges from start to burstDone_OUT high for burst_LEN N.

Reset
REQ-037 reset SHALL immediately set S=RESET_VALUE, state IDLE, burstRemain_OUT=0, burstDone_OUT=0, wrap_FLAG=0, including mid-burst.
REQ-038 After reset with enables low: systemBus_OUT, addressLow_OUT all ones, addressHigh_OUT 8'hFF, burstBusy_OUT 0.

Verification
REQ-039 Reset, addressLowWrite_EN=1 -> addressLow_OUT=8'hFD, addressHigh_OUT=8'h01.
REQ-040 load 8'h00, push -> S=8'hFF, wrap_FLAG=1; flagClear_EN -> wrap_FLAG=0; pop -> S=8'h00, wrap_FLAG=1.
REQ-041 S=8'hFD, burst_START burst_LEN=3 -> busy 3 cycles, S FD->FC->FB->FA, burstDone_OUT pulse next cycle, push_EN during burst ignored.
REQ-042 Burst of 3 with hold_EN high for 2 cycles mid-burst -> S and burstRemain_OUT frozen, burstDone_OUT delayed 2 cycles.
REQ-043 push_EN and pop_EN together at S=8'h40 -> S=8'h40; burst_LEN=0 start -> stays IDLE.
REQ-044 reset asserted mid-burst asynchronously -> S=8'hFD, burstBusy_OUT=0 before next edge, no burstDone_OUT pulse.

Source files
------------

// File: rtl/stack_pointer_unit.sv
// -----------------------------------------------------------------------------
// stack_pointer_unit
//
// Stack pointer register S for a 6502-style core, with a small burst engine
// that performs a run of back-to-back pushes (e.g. for interrupt entry).
//
// Ports:
//   phi2               system clock, all state updates on its rising edge
//   reset              asynchronous active-high reset
//   systemBus_IN       data loaded into S by load_EN (TXS)
//   load_EN            load S from systemBus_IN
//   push_EN / pop_EN   single push (S-1) / pop (S+1); both together = no-op
//   hold_EN            freeze all state (RDY low)
//   burst_START        begin a burst of burst_LEN pushes (1..MAX_BURST)
//   burst_LEN          burst length
//   flagClear_EN       clear the sticky wrap flag
//   systemBusWrite_EN  drive S onto systemBus_OUT
//   addressLowWrite_EN drive S / PAGE onto the address outputs
//   systemBus_OUT      S or all ones when not driven
//   addressLow_OUT     S or all ones when not driven
//   addressHigh_OUT    PAGE or 8'hFF when not driven
//   burstBusy_OUT      high while the burst engine is stepping
//   burstRemain_OUT    pushes still to do in the current burst
//   burstDone_OUT      one-cycle pulse after the last burst push
//   wrap_FLAG          sticky: S wrapped on a push or pop
// -----------------------------------------------------------------------------
module stack_pointer_unit #(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [7:0]        PAGE        = 8'h01,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(8'hFD),
    parameter int unsigned       MAX_BURST   = 3
) (
    input  logic             phi2,
    input  logic             reset,
    input  logic [WIDTH-1:0] systemBus_IN,
    input  logic             load_EN,
    input  logic             push_EN,
    input  logic             pop_EN,
    input  logic             hold_EN,
    input  logic             burst_START,
    input  logic [2:0]       burst_LEN,
    input  logic             flagClear_EN,
    input  logic             systemBusWrite_EN,
    input  logic             addressLowWrite_EN,
    output logic [WIDTH-1:0] systemBus_OUT,
    output logic [WIDTH-1:0] addressLow_OUT,
    output logic [7:0]       addressHigh_OUT,
    output logic             burstBusy_OUT,
    output logic [2:0]       burstRemain_OUT,
    output logic             burstDone_OUT,
    output logic             wrap_FLAG
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [2:0]       MAX_LEN = 3'(MAX_BURST);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // A decrement wraps only from zero.
    function automatic logic dec_wraps(input logic [WIDTH-1:0] s);
        return (s == {WIDTH{1'b0}});
    endfunction

    // An increment wraps only from all ones.
    function automatic logic inc_wraps(input logic [WIDTH-1:0] s);
        return (s == {WIDTH{1'b1}});
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [2:0]       remain_q, remain_d;
    logic             wrap_q, wrap_d;

    logic             start_ok_s;
    logic [WIDTH-1:0] norm_s_s;
    logic             norm_wrap_s;
    logic             wrap_evt_s;

    // An out-of-range burst length makes the start request invisible.
    assign start_ok_s = burst_START && (burst_LEN != 3'd0) && (burst_LEN <= MAX_LEN);

    // Ordinary (non-burst) update of S: load beats push/pop; push+pop cancel.
    always_comb begin
        norm_s_s    = s_q;
        norm_wrap_s = 1'b0;
        if (load_EN) begin
            norm_s_s = systemBus_IN;
        end else if (push_EN && !pop_EN) begin
            norm_s_s    = s_q - ONE;
            norm_wrap_s = dec_wraps(s_q);
        end else if (pop_EN && !push_EN) begin
            norm_s_s    = s_q + ONE;
            norm_wrap_s = inc_wraps(s_q);
        end else begin
            norm_s_s = s_q;
        end
    end

    // Next-state selection: hold > burst step > valid start > ordinary update.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        remain_d   = remain_q;
        wrap_evt_s = 1'b0;
        wrap_d     = wrap_q;
        if (hold_EN) begin
            state_d  = state_q;
            s_d      = s_q;
            remain_d = remain_q;
            wrap_d   = wrap_q;
        end else begin
            case (state_q)
                ST_BURST: begin
                    s_d        = s_q - ONE;
                    wrap_evt_s = dec_wraps(s_q);
                    remain_d   = remain_q - 3'd1;
                    if (remain_q == 3'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BURST;
                    end
                end
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_d  = ST_BURST;
                        remain_d = burst_LEN;
                    end else begin
                        s_d        = norm_s_s;
                        wrap_evt_s = norm_wrap_s;
                    end
                end
                ST_DONE: begin
                    // The done cycle still services ordinary stack traffic.
                    state_d    = ST_IDLE;
                    s_d        = norm_s_s;
                    wrap_evt_s = norm_wrap_s;
                end
                default: begin
                    state_d  = ST_IDLE;
                    remain_d = 3'd0;
                end
            endcase
            // A wrap on the clearing edge wins over the clear.
            wrap_d = (wrap_q && !flagClear_EN) || wrap_evt_s;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            s_q      <= RESET_VALUE;
            remain_q <= 3'd0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            remain_q <= remain_d;
            wrap_q   <= wrap_d;
        end
    end

    assign systemBus_OUT   = systemBusWrite_EN  ? s_q  : {WIDTH{1'b1}};
    assign addressLow_OUT  = addressLowWrite_EN ? s_q  : {WIDTH{1'b1}};
    assign addressHigh_OUT = addressLowWrite_EN ? PAGE : 8'hFF;
    assign burstBusy_OUT   = (state_q == ST_BURST);
    assign burstRemain_OUT = remain_q;
    // The pulse is suppressed while held and reappears once RDY returns.
    assign burstDone_OUT   = (state_q == ST_DONE) && !hold_EN;
    assign wrap_FLAG       = wrap_q;

endmodule
